// File: rtl/pc_fetch_unit.sv
// F-stage program counter and instruction fetcher.
// Holds the PC, fetches over a req/ack handshake and presents {F_PC, F_instr, F_valid, F_exc} to D.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic [4:0]  F_exc
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc;
  logic [31:0] tgt;
  logic        adv;
  logic        bad;
  logic        load;

  // Handshake: im_req/im_addr are combinational; a transfer completes in any cycle
  // where im_req and im_ack are both high. Without ack, PC is loaded with tgt, so the
  // next cycle re-presents the same address until ack or flush. Memory has no side
  // effects, so an abandoned request needs no cancellation.
  always_comb begin
    adv  = F_valid & ~stall & ~flush;
    tgt  = flush ? flush_pc : (adv ? npc : pc);
    bad  = (tgt[1:0] != 2'b00) | (tgt < IM_LO) | (tgt > IM_HI);
    load = flush | ~F_valid | adv;
  end

  assign im_addr = tgt;
  assign im_req  = load & ~bad & ~reset;
  assign F_PC    = pc;

  // A stalled, valid F holds everything; otherwise the slot reloads from tgt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      F_instr <= 32'h0;
      F_valid <= 1'b0;
      F_exc   <= 5'd0;
    end else if (load) begin
      pc <= tgt;
      if (bad) begin
        F_instr <= 32'h0;
        F_exc   <= EXC_ADEL;
        F_valid <= 1'b1;
      end else if (im_ack) begin
        F_instr <= im_rdata;
        F_exc   <= 5'd0;
        F_valid <= 1'b1;
      end else begin
        F_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: a combinational instruction memory returns
// {16'hC0DE, addr[15:0]}, and expected values are hand-computed constants.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_instr;
  logic        F_valid;
  logic [4:0]  F_exc;

  logic        auto_npc;
  logic [31:0] npc_man;
  logic        ack_en;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .npc(npc), .flush(flush),
    .flush_pc(flush_pc), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_rdata(im_rdata), .F_PC(F_PC), .F_instr(F_instr), .F_valid(F_valid),
    .F_exc(F_exc)
  );

  // Clock and memory / next-PC models
  always #5 clk = ~clk;

  always_comb begin
    im_rdata = {16'hC0DE, im_addr[15:0]};
    im_ack   = ack_en;
    npc      = auto_npc ? (F_PC + 32'd4) : npc_man;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_f(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic valid, input logic [4:0] exc);
    check({tag, "_pc"}, F_PC, pc);
    check({tag, "_instr"}, F_instr, instr);
    check({tag, "_valid"}, {31'd0, F_valid}, {31'd0, valid});
    check({tag, "_exc"}, {27'd0, F_exc}, {27'd0, exc});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    auto_npc = 1'b1; npc_man = 32'h0; ack_en = 1'b1;
    settle();
    check_f("reset", 32'h3000, 32'h0, 1'b0, 5'd0);
    check("reset_req", {31'd0, im_req}, 32'd0);
    tick();
    tick();

    // 1: zero-wait sequential fetch
    reset = 1'b0; settle();
    check("t1_req0", {31'd0, im_req}, 32'd1);
    check("t1_addr0", im_addr, 32'h3000);
    tick();
    check_f("t1_c1", 32'h3000, 32'hC0DE_3000, 1'b1, 5'd0);
    check("t1_addr1", im_addr, 32'h3004);
    tick();
    check_f("t1_c2", 32'h3004, 32'hC0DE_3004, 1'b1, 5'd0);
    check("t1_addr2", im_addr, 32'h3008);

    // 2: two wait cycles at 3008
    ack_en = 1'b0;
    tick();
    check("t2_valid0", {31'd0, F_valid}, 32'd0);
    check("t2_addr0", im_addr, 32'h3008);
    check("t2_req0", {31'd0, im_req}, 32'd1);
    tick();
    check("t2_valid1", {31'd0, F_valid}, 32'd0);
    check("t2_addr1", im_addr, 32'h3008);
    ack_en = 1'b1;
    tick();
    check_f("t2_done", 32'h3008, 32'hC0DE_3008, 1'b1, 5'd0);

    // 3: stall for three cycles, then take a branch target
    stall = 1'b1; auto_npc = 1'b0; npc_man = 32'h3040; settle();
    check("t3_req_stall", {31'd0, im_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_f("t3_hold", 32'h3008, 32'hC0DE_3008, 1'b1, 5'd0);
      check("t3_req_hold", {31'd0, im_req}, 32'd0);
    end
    stall = 1'b0; settle();
    check("t3_addr_rel", im_addr, 32'h3040);
    tick();
    check_f("t3_branch", 32'h3040, 32'hC0DE_3040, 1'b1, 5'd0);

    // 4: address errors and the legal upper bound
    npc_man = 32'h3002; settle();
    check("t4_req_mis", {31'd0, im_req}, 32'd0);
    tick();
    check_f("t4_mis", 32'h3002, 32'h0, 1'b1, 5'd4);
    npc_man = 32'h2FFC; tick();
    check_f("t4_low", 32'h2FFC, 32'h0, 1'b1, 5'd4);
    npc_man = 32'h7000; tick();
    check_f("t4_high", 32'h7000, 32'h0, 1'b1, 5'd4);
    npc_man = 32'hFFFF_FFFC; tick();
    check_f("t4_wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 5'd4);
    npc_man = 32'h6FFC; settle();
    check("t4_req_top", {31'd0, im_req}, 32'd1);
    tick();
    check_f("t4_top", 32'h6FFC, 32'hC0DE_6FFC, 1'b1, 5'd0);

    // 5: flush during stall with a pending wait-state fetch
    npc_man = 32'h3000; ack_en = 1'b0; tick();
    check("t5_pending", {31'd0, F_valid}, 32'd0);
    stall = 1'b1; flush = 1'b1; flush_pc = 32'h4180; settle();
    check("t5_flush_addr", im_addr, 32'h4180);
    check("t5_flush_req", {31'd0, im_req}, 32'd1);
    tick();
    flush = 1'b0; settle();
    check("t5_pc", F_PC, 32'h4180);
    check("t5_valid", {31'd0, F_valid}, 32'd0);
    check("t5_addr", im_addr, 32'h4180);
    ack_en = 1'b1; tick();
    check_f("t5_ack", 32'h4180, 32'hC0DE_4180, 1'b1, 5'd0);
    check("t5_req_stall", {31'd0, im_req}, 32'd0);
    tick();
    check_f("t5_held", 32'h4180, 32'hC0DE_4180, 1'b1, 5'd0);

    // 6: reset mid-wait
    stall = 1'b0; npc_man = 32'h4184; ack_en = 1'b0; tick();
    check("t6_wait_pc", F_PC, 32'h4184);
    check("t6_wait_valid", {31'd0, F_valid}, 32'd0);
    #2;
    reset = 1'b1; settle();
    check_f("t6_reset", 32'h3000, 32'h0, 1'b0, 5'd0);
    check("t6_req", {31'd0, im_req}, 32'd0);
    tick();
    reset = 1'b0; ack_en = 1'b1; settle();
    check("t6_addr", im_addr, 32'h3000);
    tick();
    check_f("t6_restart", 32'h3000, 32'hC0DE_3000, 1'b1, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
